// File: rtl/ps2_pkg.sv
// Shared types, command bytes and helpers for the PS/2 host transmit path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    // Index of the stop bit in the {stop, parity, data} shift register.
    localparam logic [3:0] STOP_IDX = 4'd9;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises PS2_CLK/PS2_DATA, debounces the clock level and emits a
// one-cycle strobe on each accepted falling edge. Shared with the receive path.
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_pin_i,
    input  logic data_pin_i,
    output logic clk_level_o,
    output logic data_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fall_q, fall_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            level_q     <= 1'b1;
            cnt_q       <= '0;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], clk_pin_i};
            data_sync_q <= {data_sync_q[0], data_pin_i};
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            fall_q      <= fall_d;
        end
    end

    // cnt_q holds how many consecutive samples have disagreed with the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (clk_sync_q[1] != level_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_d = clk_sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        fall_d = level_q & ~level_d;
    end

    assign clk_level_o = level_q;
    assign data_o      = data_sync_q[1];
    assign fall_o      = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts
// out one command frame on device clock edges and checks the device ACK.
import ps2_pkg::*;

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int START_TIMEOUT  = 1500000,
    parameter int XFER_TIMEOUT   = 200000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int TO_MAX = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int T_MAX  = (TO_MAX > INHIBIT_CYCLES) ? TO_MAX : INHIBIT_CYCLES;
    localparam int TW     = $clog2(T_MAX + 1);

    logic clk_level, data_s, fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk        (clk),
        .rst        (rst),
        .clk_pin_i  (ps2_clk_in),
        .data_pin_i (ps2_data_in),
        .clk_level_o(clk_level),
        .data_o     (data_s),
        .fall_o     (fall)
    );

    ps2_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [9:0]    shreg_q, shreg_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 1'b1;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        data_oe_d = data_oe_q;

        unique case (state_q)
            IDLE: begin
                timer_d   = '0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    shreg_d  = {1'b1, odd_parity(tx_data), tx_data};
                    bitcnt_d = '0;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (timer_q == TW'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;
                    state_d   = REQ;
                end
            end
            // The first device fall already shifts out data bit 0.
            REQ: begin
                if (fall) begin
                    data_oe_d = ~shreg_q[0];
                    bitcnt_d  = 4'd1;
                    state_d   = SEND;
                end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
                    state_d = ERR;
                end
            end
            SEND: begin
                if (fall) begin
                    data_oe_d = ~shreg_q[bitcnt_q];
                    bitcnt_d  = bitcnt_q + 1'b1;
                    if (bitcnt_q == STOP_IDX) begin
                        state_d = ACK;
                    end
                end else if (timer_q == TW'(XFER_TIMEOUT - 1)) begin
                    state_d = ERR;
                end
            end
            ACK: begin
                if (fall) begin
                    state_d = data_s ? ERR : WAIT_IDLE;
                end else if (timer_q == TW'(XFER_TIMEOUT - 1)) begin
                    state_d = ERR;
                end
            end
            WAIT_IDLE: begin
                if (data_s && clk_level) begin
                    state_d = DONE;
                end else if (timer_q == TW'(XFER_TIMEOUT - 1)) begin
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end
        if (state_d == ERR) begin
            data_oe_d = 1'b0;
        end
        clk_oe_d = (state_d == INHIBIT);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        err_d    = (state_d == ERR);
    end

    assign tx_ready    = (state_q == IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign tx_done     = done_q;
    assign tx_error    = err_q;

endmodule
